// File: rtl/single_cycle_cpu_pkg.sv
// Shared encodings for the single-cycle MIPS-subset CPU: opcodes, functs,
// ALU operation selector and the decoded control bundle.
package single_cycle_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    reg_dst;     // 1: rd, 0: rt
    logic    alu_src;     // 1: sign-extended immediate
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/single_cycle_cpu_dmem.sv
// Word-addressed data RAM: combinational read, rising-edge write,
// cleared by reset so every run starts from a known image.
module single_cycle_cpu_dmem
  import single_cycle_cpu_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wd,
  output logic [31:0]   o_rd
);

  logic [31:0] mem [0:DEPTH-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (i_we) begin
      mem[i_addr] <= i_wd;
    end
  end

  assign o_rd = mem[i_addr];

endmodule

// File: rtl/single_cycle_cpu_regfile.sv
// 32x32 register file: two combinational read ports, one write port.
// $0 is hardwired to zero and writes to it are dropped.
module single_cycle_cpu_regfile
  import single_cycle_cpu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);

  logic [31:0] registers [0:31];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (i_we && (i_wa != 5'd0)) begin
      registers[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : registers[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : registers[i_ra2];

endmodule

// File: rtl/single_cycle_cpu.sv
// Single-cycle MIPS-subset CPU: PC, self-test ROM, decoder, ALU, register
// file and data RAM; one instruction retires per rising clock edge.
module single_cycle_cpu
  import single_cycle_cpu_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  output logic [31:0] alu_result
);

  localparam int DMEM_AW = $clog2(DMEM_WORDS);

  logic [31:0] r_pc;
  logic [31:0] instruction;
  logic [29:0] w_word_idx;
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  ctrl_t       w_ctrl;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu;
  logic [31:0] w_mem_rd;
  logic [31:0] w_wb_data;
  logic [4:0]  w_wa;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;

  // Self-test program; anything past the ROM fetches 0 (sll $0 = NOP).
  assign w_word_idx = r_pc[31:2];
  always_comb begin
    instruction = 32'h0;
    if (w_word_idx < 30'(IMEM_WORDS)) begin
      case (w_word_idx)
        30'd0:   instruction = 32'h20080005;
        30'd1:   instruction = 32'h20090003;
        30'd2:   instruction = 32'h20100100;
        30'd3:   instruction = 32'h01095020;
        30'd4:   instruction = 32'hAE0A0000;
        30'd5:   instruction = 32'h01095822;
        30'd6:   instruction = 32'hAE0B0004;
        30'd7:   instruction = 32'h01096024;
        30'd8:   instruction = 32'hAE0C0008;
        30'd9:   instruction = 32'h01096825;
        30'd10:  instruction = 32'hAE0D000C;
        30'd11:  instruction = 32'h0128702A;
        30'd12:  instruction = 32'hAE0E0010;
        30'd13:  instruction = 32'h210F000A;
        30'd14:  instruction = 32'hAE0F0014;
        30'd15:  instruction = 32'h8E180000;
        30'd16:  instruction = 32'h130A0001;
        30'd17:  instruction = 32'h20190055;
        30'd18:  instruction = 32'h20190001;
        30'd19:  instruction = 32'h1000FFFF;
        default: instruction = 32'h0;
      endcase
    end
  end

  assign w_op    = instruction[31:26];
  assign w_rs    = instruction[25:21];
  assign w_rt    = instruction[20:16];
  assign w_rd    = instruction[15:11];
  assign w_funct = instruction[5:0];
  assign w_imm   = sext16(instruction[15:0]);

  // Unlisted opcodes and functs leave every enable low, i.e. a NOP.
  always_comb begin
    w_ctrl        = '0;
    w_ctrl.alu_op = ALU_ADD;
    case (w_op)
      OP_RTYPE: begin
        w_ctrl.reg_dst = 1'b1;
        case (w_funct)
          FN_ADD: begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_ADD; end
          FN_SUB: begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_SUB; end
          FN_AND: begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_AND; end
          FN_OR:  begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_OR;  end
          FN_SLT: begin w_ctrl.reg_write = 1'b1; w_ctrl.alu_op = ALU_SLT; end
          default: w_ctrl.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
      end
      OP_LW: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        w_ctrl.branch = 1'b1;
        w_ctrl.alu_op = ALU_SUB;
      end
      default: w_ctrl.branch = 1'b0;
    endcase
  end

  assign w_alu_b = w_ctrl.alu_src ? w_imm : w_rd2;

  always_comb begin
    case (w_ctrl.alu_op)
      ALU_ADD: w_alu = w_rd1 + w_alu_b;
      ALU_SUB: w_alu = w_rd1 - w_alu_b;
      ALU_AND: w_alu = w_rd1 & w_alu_b;
      ALU_OR:  w_alu = w_rd1 | w_alu_b;
      ALU_SLT: w_alu = {31'd0, ($signed(w_rd1) < $signed(w_alu_b))};
      default: w_alu = w_rd1 + w_alu_b;
    endcase
  end

  assign w_wa      = w_ctrl.reg_dst ? w_rd : w_rt;
  assign w_wb_data = w_ctrl.mem_to_reg ? w_mem_rd : w_alu;

  single_cycle_cpu_regfile u_regfile (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_we    (w_ctrl.reg_write),
    .i_ra1   (w_rs),
    .i_ra2   (w_rt),
    .i_wa    (w_wa),
    .i_wd    (w_wb_data),
    .o_rd1   (w_rd1),
    .o_rd2   (w_rd2)
  );

  single_cycle_cpu_dmem #(.DEPTH(DMEM_WORDS)) u_dmem (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_we    (w_ctrl.mem_write),
    .i_addr  (w_alu[DMEM_AW+1:2]),
    .i_wd    (w_rd2),
    .o_rd    (w_mem_rd)
  );

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_next  = (w_ctrl.branch && (w_rd1 == w_rd2))
                    ? w_pc_plus4 + {w_imm[29:0], 2'b00}
                    : w_pc_plus4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pc <= '0;
    else      r_pc <= w_pc_next;
  end

  assign pc_out     = r_pc;
  assign alu_result = w_alu;

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed bench for single_cycle_cpu: per-cycle PC/ALU vector table for the
// self-test program, end-state peeks, $0 protection and async mid-run reset.
module tb_single_cycle_cpu;

  logic        clk;
  logic        rst;
  logic [31:0] pc_out;
  logic [31:0] alu_result;

  int errors = 0;
  int checks = 0;
  logic saw_skipped = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
  } vec_t;

  vec_t vecs [20];

  single_cycle_cpu dut (
    .clk        (clk),
    .rst        (rst),
    .pc_out     (pc_out),
    .alu_result (alu_result)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(dut.instruction) begin
    if (dut.instruction == 32'h20190055) saw_skipped = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_final(input string tag);
    logic [31:0] exp_mem [6];
    int          reg_idx [11];
    logic [31:0] reg_val [11];
    exp_mem = '{32'd8, 32'd2, 32'd1, 32'd7, 32'd1, 32'd15};
    reg_idx = '{8, 9, 10, 11, 12, 13, 14, 15, 16, 24, 25};
    reg_val = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd1, 32'd7, 32'd1, 32'd15,
                32'h100, 32'd8, 32'd1};
    for (int i = 0; i < 6; i++)
      check($sformatf("%s mem[%0d]", tag, 64 + i), dut.u_dmem.mem[64 + i], exp_mem[i]);
    for (int i = 0; i < 11; i++)
      check($sformatf("%s reg[%0d]", tag, reg_idx[i]),
            dut.u_regfile.registers[reg_idx[i]], reg_val[i]);
    check($sformatf("%s reg[0]", tag), dut.u_regfile.registers[0], 32'd0);
    check($sformatf("%s mem[70]", tag), dut.u_dmem.mem[70], 32'd0);
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int halt_bad;

    vecs[0]  = '{32'h00, 32'd5};
    vecs[1]  = '{32'h04, 32'd3};
    vecs[2]  = '{32'h08, 32'h100};
    vecs[3]  = '{32'h0C, 32'd8};
    vecs[4]  = '{32'h10, 32'h100};
    vecs[5]  = '{32'h14, 32'd2};
    vecs[6]  = '{32'h18, 32'h104};
    vecs[7]  = '{32'h1C, 32'd1};
    vecs[8]  = '{32'h20, 32'h108};
    vecs[9]  = '{32'h24, 32'd7};
    vecs[10] = '{32'h28, 32'h10C};
    vecs[11] = '{32'h2C, 32'd1};
    vecs[12] = '{32'h30, 32'h110};
    vecs[13] = '{32'h34, 32'd15};
    vecs[14] = '{32'h38, 32'h114};
    vecs[15] = '{32'h3C, 32'h100};
    vecs[16] = '{32'h40, 32'd0};
    vecs[17] = '{32'h48, 32'd1};
    vecs[18] = '{32'h4C, 32'd0};
    vecs[19] = '{32'h4C, 32'd0};

    // Reset held across several edges
    rst = 1'b0;
    run_cycles(2);
    #1;
    check("reset pc_out", pc_out, 32'd0);
    check("reset alu_result", alu_result, 32'd5);
    for (int i = 0; i < 32; i++)
      check($sformatf("reset reg[%0d]", i), dut.u_regfile.registers[i], 32'd0);
    check("reset mem[64]", dut.u_dmem.mem[64], 32'd0);

    // Release and follow the program cycle by cycle
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      check($sformatf("cycle %0d pc_out", i), pc_out, vecs[i].pc);
      check($sformatf("cycle %0d alu_result", i), alu_result, vecs[i].alu);
    end

    halt_bad = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (pc_out !== 32'h4C || alu_result !== 32'd0) halt_bad++;
    end
    check("halt cycles off 0x4C", 32'(halt_bad), 32'd0);
    check("skipped instr fetched", {31'd0, saw_skipped}, 32'd0);
    check_final("run1");

    // Forced write to $0 must be discarded
    @(negedge clk);
    force dut.instruction = 32'h20000007;
    #1;
    check("force alu_result", alu_result, 32'd7);
    @(negedge clk);
    #1;
    check("force reg[0]", dut.u_regfile.registers[0], 32'd0);
    check("force reg[9] kept", dut.u_regfile.registers[9], 32'd3);
    release dut.instruction;

    // Fresh start, then async reset at cycle 8 away from any clock edge
    rst = 1'b0;
    run_cycles(2);
    rst = 1'b1;
    run_cycles(8);
    #1;
    check("midrun pc before reset", pc_out, 32'h20);
    #1;
    rst = 1'b0;
    #1;
    check("midrun async pc_out", pc_out, 32'd0);
    check("midrun async reg[8]", dut.u_regfile.registers[8], 32'd0);
    check("midrun async mem[64]", dut.u_dmem.mem[64], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_cycles(100);
    #1;
    check("rerun pc_out", pc_out, 32'h4C);
    check("rerun skipped instr", {31'd0, saw_skipped}, 32'd0);
    check_final("rerun");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
